// File: rtl/loader_pkg.sv
// Shared definitions for the UART instruction-memory loader.
package loader_pkg;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam logic [31:0] TERM_WORD_DEF  = 32'hFFFF_FFFF;
    localparam int unsigned BYTES_PER_WORD = 4;

endpackage

// File: rtl/uart_imem_loader.sv
// Packs UART bytes into little-endian words and writes them to sequential
// imem addresses until the terminator word arrives or memory fills.
module uart_imem_loader
    import loader_pkg::*;
#(
    parameter int unsigned ADDR_W    = 8,
    parameter logic [31:0] TERM_WORD = TERM_WORD_DEF,
    parameter logic [15:0] TIMEOUT   = 16'd50000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_en,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    input  logic              rx_break,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [ADDR_W:0]   word_count,
    output logic              write_done,
    output logic              overflow
);

    localparam int unsigned       TO_W     = $clog2(32'(TIMEOUT) + 1);
    localparam logic [TO_W-1:0]   TO_LIM   = TO_W'(TIMEOUT);
    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
    localparam logic [1:0]        LAST_IDX = 2'(BYTES_PER_WORD - 1);

    state_e            state_q, state_d;
    logic [1:0]        idx_q, idx_d;
    logic [31:0]       asm_q, asm_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic [TO_W-1:0]   to_q, to_d;
    logic              done_q, done_d;
    logic              ovf_q, ovf_d;
    logic [31:0]       asm_word;
    logic              accept;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= LOAD;
            idx_q   <= '0;
            asm_q   <= '0;
            wdata_q <= '0;
            addr_q  <= '0;
            cnt_q   <= '0;
            to_q    <= '0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            asm_q   <= asm_d;
            wdata_q <= wdata_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            to_q    <= to_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        asm_d    = asm_q;
        wdata_d  = wdata_q;
        addr_d   = addr_q;
        cnt_d    = cnt_q;
        to_d     = to_q;
        done_d   = done_q;
        ovf_d    = ovf_q;
        imem_we  = 1'b0;
        accept   = rx_valid & load_en & ~rx_break;
        asm_word = asm_q;
        asm_word[{idx_q, 3'b000} +: 8] = rx_data;

        if (state_q == WRITE) begin
            imem_we = 1'b1;
            cnt_d   = cnt_q + 1'b1;
            if (addr_q == ADDR_MAX) begin
                ovf_d   = 1'b1;
                done_d  = 1'b1;
                state_d = DONE;
            end else begin
                addr_d  = addr_q + 1'b1;
                state_d = LOAD;
            end
        end

        // Byte assembly runs in WRITE too so a byte arriving during the write is kept.
        if (state_q != DONE) begin
            if (rx_break) begin
                idx_d = '0;
                to_d  = '0;
            end else if (accept) begin
                asm_d = asm_word;
                to_d  = '0;
                if (idx_q == LAST_IDX) begin
                    wdata_d = asm_word;
                    idx_d   = '0;
                    if (asm_word == TERM_WORD) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = WRITE;
                    end
                end else begin
                    idx_d = idx_q + 2'd1;
                end
            end else if (idx_q != 2'd0) begin
                if (to_q == TO_LIM) begin
                    idx_d = '0;
                    to_d  = '0;
                end else begin
                    to_d = to_q + 1'b1;
                end
            end
        end
    end

    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign word_count = cnt_q;
    assign write_done = done_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_uart_imem_loader.sv
// Self-checking bench for uart_imem_loader: directed table, corner sequences
// and randomized traffic against a queue-based reference model.
module tb_uart_imem_loader;

    localparam int unsigned ADDR_W  = 2;
    localparam int unsigned DEPTH   = 1 << ADDR_W;
    localparam logic [15:0] TIMEOUT = 16'd30;
    localparam logic [31:0] TERM    = 32'hFFFF_FFFF;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              load_en = 1'b0;
    logic              rx_valid = 1'b0;
    logic [7:0]        rx_data = '0;
    logic              rx_break = 1'b0;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic [ADDR_W:0]   word_count;
    logic              write_done;
    logic              overflow;

    int checks = 0;
    int errors = 0;

    uart_imem_loader #(.ADDR_W(ADDR_W), .TERM_WORD(TERM), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .load_en(load_en), .rx_valid(rx_valid),
        .rx_data(rx_data), .rx_break(rx_break), .imem_we(imem_we),
        .imem_addr(imem_addr), .imem_wdata(imem_wdata), .word_count(word_count),
        .write_done(write_done), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Observed writes, recorded away from the active edge.
    logic [ADDR_W-1:0] obs_addr[$];
    logic [31:0]       obs_data[$];
    always @(negedge clk) begin
        if (!rst && imem_we) begin
            obs_addr.push_back(imem_addr);
            obs_data.push_back(imem_wdata);
        end
    end

    // Reference model: bytes collected in a queue, idle cycles counted since last byte.
    logic [7:0]  m_bytes[$];
    int          m_idle;
    bit          m_pend;
    logic [31:0] m_word;
    int          m_addr;
    int          m_cnt;
    bit          m_done;
    bit          m_ovf;

    task automatic model_reset();
        m_bytes.delete();
        m_idle = 0; m_pend = 0; m_word = '0;
        m_addr = 0; m_cnt = 0; m_done = 0; m_ovf = 0;
    endtask

    task automatic model_update(input bit v, input logic [7:0] d, input bit brk, input bit en);
        if (m_done) return;
        if (m_pend) begin
            m_pend = 0;
            m_cnt++;
            if (m_addr == DEPTH - 1) begin
                m_ovf = 1; m_done = 1;
            end else m_addr++;
        end
        if (m_done) return;
        if (brk) begin
            m_bytes.delete(); m_idle = 0;
        end else if (v && en) begin
            m_bytes.push_back(d);
            m_idle = 0;
            if (m_bytes.size() == 4) begin
                logic [31:0] w;
                w = 32'(m_bytes[0]) + (32'(m_bytes[1]) << 8) + (32'(m_bytes[2]) << 16) + (32'(m_bytes[3]) << 24);
                m_bytes.delete();
                if (w == TERM) m_done = 1;
                else begin m_pend = 1; m_word = w; end
            end
        end else if (m_bytes.size() > 0) begin
            m_idle++;
            if (m_idle > int'(TIMEOUT)) begin
                m_bytes.delete(); m_idle = 0;
            end
        end
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input bit v, input logic [7:0] d, input bit brk, input bit en);
        rx_valid = v; rx_data = d; rx_break = brk; load_en = en;
        chk("model_outputs",
            {28'd0, imem_we, write_done, overflow, 1'b0, 29'(word_count), 3'(imem_addr)},
            {28'd0, m_pend, m_done, m_ovf, 1'b0, 29'(m_cnt), 3'(m_addr)});
        if (m_pend) chk("model_wdata", 64'(imem_wdata), 64'(m_word));
        model_update(v, d, brk, en);
        @(posedge clk); #1;
        rx_valid = 1'b0; rx_break = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] d);
        step(1, d, 0, 1);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int unsigned i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 8'h00, 0, 1);
    endtask

    task automatic do_reset();
        rst = 1'b1; rx_valid = 1'b0; rx_break = 1'b0; load_en = 1'b1;
        #2;
        chk("reset_outputs",
            64'({imem_we, imem_addr, imem_wdata, word_count, write_done, overflow}), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        obs_addr.delete(); obs_data.delete();
    endtask

    typedef struct {
        bit          v;
        logic [7:0]  d;
        bit          we;
        logic [1:0]  addr;
        logic [31:0] wdata;
        logic [2:0]  cnt;
        bit          done;
    } vec_t;

    vec_t tbl[10];

    initial begin
        model_reset();
        tbl[0] = '{1, 8'h13, 0, 2'd0, 32'h0,          3'd0, 0};
        tbl[1] = '{1, 8'h01, 0, 2'd0, 32'h0,          3'd0, 0};
        tbl[2] = '{1, 8'h01, 0, 2'd0, 32'h0,          3'd0, 0};
        tbl[3] = '{1, 8'hFD, 0, 2'd0, 32'h0,          3'd0, 0};
        tbl[4] = '{0, 8'h00, 1, 2'd0, 32'hFD01_0113, 3'd0, 0};
        tbl[5] = '{1, 8'hFF, 0, 2'd1, 32'h0,          3'd1, 0};
        tbl[6] = '{1, 8'hFF, 0, 2'd1, 32'h0,          3'd1, 0};
        tbl[7] = '{1, 8'hFF, 0, 2'd1, 32'h0,          3'd1, 0};
        tbl[8] = '{1, 8'hFF, 0, 2'd1, 32'h0,          3'd1, 0};
        tbl[9] = '{0, 8'h00, 0, 2'd1, 32'h0,          3'd1, 1};

        @(posedge clk); #1;
        do_reset();

        // Normal load, table-driven against fixed expectations.
        for (int i = 0; i < 10; i++) begin
            chk("tbl_we_addr_cnt_done", 64'({imem_we, imem_addr, word_count, write_done}),
                64'({tbl[i].we, tbl[i].addr, tbl[i].cnt, tbl[i].done}));
            if (tbl[i].we) chk("tbl_wdata", 64'(imem_wdata), 64'(tbl[i].wdata));
            step(tbl[i].v, tbl[i].d, 0, 1);
        end
        chk("normal_nwrites", 64'(obs_addr.size()), 64'd1);
        chk("normal_flags", 64'({write_done, overflow, word_count}), 64'({1'b1, 1'b0, 3'd1}));

        // Sequential words, then a second terminator after done.
        do_reset();
        send_word(32'h1111_0000); send_word(32'h2222_0001); idle(3); send_word(32'h3333_0002);
        send_word(TERM); idle(3);
        chk("seq_nwrites", 64'(obs_addr.size()), 64'd3);
        if (obs_addr.size() == 3) begin
            chk("seq_addrs", 64'({obs_addr[0], obs_addr[1], obs_addr[2]}), 64'({2'd0, 2'd1, 2'd2}));
            chk("seq_data2", 64'(obs_data[2]), 64'h3333_0002);
        end
        chk("seq_count", 64'(word_count), 64'd3);
        send_word(TERM); send_word(32'h1234_5678); idle(3);
        chk("seq_after_done", 64'(obs_addr.size()), 64'd3);

        // Timeout drops a stale partial word.
        do_reset();
        send_byte(8'hAA); send_byte(8'hBB); idle(int'(TIMEOUT) + 5);
        send_byte(8'h23); send_byte(8'h26); send_byte(8'h81); send_byte(8'h02); idle(3);
        chk("timeout_nwrites", 64'(obs_addr.size()), 64'd1);
        if (obs_addr.size() == 1)
            chk("timeout_write", 64'({obs_addr[0], obs_data[0]}), 64'({2'd0, 32'h0281_2623}));

        // Break discards partial bytes, including a simultaneous byte.
        do_reset();
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); step(1, 8'h04, 1, 1);
        send_word(32'hCAFE_F00D); idle(3);
        chk("break_nwrites", 64'(obs_addr.size()), 64'd1);
        if (obs_addr.size() == 1)
            chk("break_write", 64'({obs_addr[0], obs_data[0]}), 64'({2'd0, 32'hCAFE_F00D}));

        // Overflow at a full memory; back-to-back bytes also exercise accept-during-write.
        do_reset();
        for (int unsigned i = 0; i < DEPTH; i++) send_word(32'hA000_0000 + i);
        idle(2);
        chk("ovf_nwrites", 64'(obs_addr.size()), 64'(DEPTH));
        if (obs_addr.size() == DEPTH)
            chk("ovf_addrs", 64'({obs_addr[0], obs_addr[1], obs_addr[2], obs_addr[3]}),
                64'({2'd0, 2'd1, 2'd2, 2'd3}));
        chk("ovf_flags", 64'({overflow, write_done, word_count}), 64'({1'b1, 1'b1, 3'd4}));
        send_word(32'h5555_5555); idle(2);
        chk("ovf_no_fifth", 64'(obs_addr.size()), 64'(DEPTH));

        // Reset mid-word, then load_en low ignores bytes.
        do_reset();
        send_byte(8'h77); send_byte(8'h88);
        do_reset();
        send_word(32'h0BAD_BEEF); idle(2);
        chk("rst_mid_nwrites", 64'(obs_addr.size()), 64'd1);
        if (obs_addr.size() == 1)
            chk("rst_mid_write", 64'({obs_addr[0], obs_data[0]}), 64'({2'd0, 32'h0BAD_BEEF}));
        for (int i = 0; i < 4; i++) step(1, 8'h5A, 0, 0);
        idle(3);
        chk("load_en_low", 64'({obs_addr.size(), word_count}), 64'({32'd1, 3'd1}));

        // Randomized traffic against the model.
        for (int it = 0; it < 12; it++) begin
            do_reset();
            for (int n = 0; n < 160; n++) begin
                int unsigned r;
                r = $urandom_range(0, 99);
                if (r < 3) idle(int'(TIMEOUT) + 3 + int'($urandom_range(0, 5)));
                else if (r < 5) send_word(TERM);
                else if (r < 8) step(bit'($urandom_range(0, 1)), 8'($urandom), 1, 1);
                else step(bit'($urandom_range(0, 1)), 8'($urandom), 0, $urandom_range(0, 9) != 0);
            end
            idle(2);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
